save_state_chunk: RTL and testbench
===================================

// Module: save_state_chunk
// PURPOSE
//  Per-chunk endpoint on one slot of the save-state memory streamer's COUNT-wide chunk bus.
//  Gather (save): answers descriptor query, serves elements from local RAM.
//  Scatter (restore): checks the incoming header, writes elements into local RAM.
//  One instance per saved RAM/register bank; its data_ack/read_data feed slot N of the streamer.
// PARAMETERS
//  CHUNK_WORDS   1024  element count of this chunk (header LEN field)
//  WIDTH_CODE    1     element width: 0=8b, 1=16b, 2=32b, 3=64b (header WIDTH field)
//  ADDR_W        10    ram_addr width; CHUNK_WORDS <= 2**ADDR_W
//  READ_LATENCY  1     cycles from ram_rd accepted to ram_rdata valid (1..4)
//  DATA_W = 8<<WIDTH_CODE (localparam)
// PORTS
//  clk            in   1       system clock
//  reset_n        in   1       async reset, active low
//  enable         in   1       core paused, RAM owned by this block; 0 => never ack
//  chunk_sel      in   1       this slot's bit of streamer chunk_select
//  query_req      in   1       descriptor query/header phase
//  write_req      in   1       streamer->chunk element (or header while query_req)
//  write_data     in   64      element / header
//  read_req       in   1       chunk->streamer element request (or descriptor while query_req)
//  chunk_address  in   32      element index within chunk
//  data_ack       out  1       one-cycle accept/valid pulse
//  read_data      out  64      descriptor or element, zero-extended; valid while data_ack=1
//  ram_addr       out  ADDR_W  local RAM element address
//  ram_wdata      out  DATA_W  local RAM write data
//  ram_we         out  1       write strobe, held until ram_ready
//  ram_rd         out  1       read strobe, held until ram_ready
//  ram_rdata      in   DATA_W  local RAM read data
//  ram_ready      in   1       RAM accepts strobe this cycle
//  busy           out  1       FSM not IDLE
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE; all outputs 0. Clock and reset are decided: clk, async active-low reset_n.
//  - Request valid: req_v = enable & chunk_sel & (read_req | write_req).
//    Acted on only in IDLE; all outputs registered.
//  - States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, ACK, HOLD.
//  - IDLE, query_req & read_req: read_data = {30'b0, WIDTH_CODE[1:0], CHUNK_WORDS[31:0]} -> ACK.
//    data_ack high one cycle after the request (streamer timeout is 15 cycles).
//  - IDLE, query_req & write_req: accept only if write_data[31:0]==CHUNK_WORDS and write_data[33:32]==WIDTH_CODE -> ACK.
//    On mismatch, stay IDLE and never ack; the streamer times out and skips the chunk.
//  - IDLE, read_req (no query): chunk_address < CHUNK_WORDS -> ram_addr = chunk_address[ADDR_W-1:0], ram_rd=1, RD_ISSUE.
//    Otherwise read_data=0 -> ACK.
//  - RD_ISSUE: hold ram_rd/ram_addr until ram_ready; then drop ram_rd, load latency counter -> RD_WAIT.
//  - RD_WAIT: after READ_LATENCY cycles, read_data = zero-extended ram_rdata -> ACK.
//  - IDLE, write_req (no query): chunk_address < CHUNK_WORDS -> ram_wdata = write_data[DATA_W-1:0], ram_we=1, WR_ISSUE.
//    Otherwise discard the element -> ACK.
//  - WR_ISSUE: hold ram_we until ram_ready; drop ram_we -> ACK.
//  - ACK: data_ack=1 for exactly one cycle, read_data stable -> HOLD.
//  - HOLD: read_data held; wait until read_req=0 and write_req=0 -> IDLE (prevents double-ack on a stale req).
//  - Abort: chunk_sel=0 or enable=0 in any non-IDLE state -> IDLE next edge.
//    On abort: ram_rd/ram_we/data_ack cleared, no ack issued, in-flight RAM read result dropped.
//  - read_req and write_req both high: read wins; not produced by a correct streamer.
//  - Latency: element read = 3 + READ_LATENCY cycles req->ack with ram_ready=1; element write = 3 cycles.
//  - busy = (state != IDLE).
// STRUCTURE
//  - save_state_pkg: header field constants LEN [31:0], WIDTH [33:32], INDEX [63:56],
//    end marker (byte 7 = 8'hFF), width codes W8/W16/W32/W64, and a chunk_state_t enum.
//  - Shared with the streamer; single flat FSM, no sub-module.
// TESTING
//  1 Gather query: sel=1, query_req=read_req=1 -> data_ack 1 cycle later;
//    read_data=64'h0000_0001_0000_0400 (W16, 1024).
//  2 Scatter header 64'h0000_0001_0000_0400 -> ack.
//    Header 64'h0000_0001_0000_0200 -> no data_ack for >=16 cycles.
//  3 Write elem: chunk_address=5, write_data=64'hDEAD_BEEF_CAFE_1234 -> ram_we, ram_addr=5, ram_wdata=16'h1234, one ack.
//  4 Read elem 5, READ_LATENCY=2, ram_ready low 3 cycles -> ram_rd held 4 cycles;
//    read_data=64'h1234 with ack; ack never repeats while req held.
//  5 chunk_address=1024 read -> ack, read_data=0, no ram_rd; write -> ack, no ram_we.
//  6 reset_n low in RD_WAIT, and chunk_sel drop in WR_ISSUE -> IDLE, outputs 0, no ack.
//    Next request serviced normally.

Source files
------------

// File: rtl/save_state_pkg.sv
// Shared definitions for the save-state streamer and its per-chunk endpoints.
//   Header layout : LEN [31:0], WIDTH [33:32], INDEX [63:56]
//   End marker    : header byte 7 == 8'hFF
//   Width codes   : W8/W16/W32/W64
//   chunk_state_t : endpoint FSM states
package save_state_pkg;

  localparam int HDR_LEN_LSB   = 0;
  localparam int HDR_LEN_MSB   = 31;
  localparam int HDR_WIDTH_LSB = 32;
  localparam int HDR_WIDTH_MSB = 33;
  localparam int HDR_INDEX_LSB = 56;
  localparam int HDR_INDEX_MSB = 63;

  localparam logic [7:0] HDR_END_MARKER = 8'hFF;

  localparam logic [1:0] W8  = 2'd0;
  localparam logic [1:0] W16 = 2'd1;
  localparam logic [1:0] W32 = 2'd2;
  localparam logic [1:0] W64 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_ISSUE,
    ST_ACK,
    ST_HOLD
  } chunk_state_t;

  // Descriptor returned on a gather query: {30'b0, WIDTH, LEN}.
  function automatic logic [63:0] make_descriptor(input logic [1:0] width,
                                                  input logic [31:0] len);
    return {30'b0, width, len};
  endfunction

endpackage

// File: rtl/save_state_chunk.sv
// Per-chunk endpoint on one slot of the save-state streamer chunk bus.
// Gather: answers the descriptor query and serves elements from local RAM.
// Scatter: checks the incoming header and writes elements into local RAM.
//
// Ports
//   clk, reset_n                    clock, async active-low reset
//   enable, chunk_sel               RAM ownership / slot select (drop => abort)
//   query_req, read_req, write_req  streamer request strobes
//   write_data, chunk_address       element/header data, element index
//   data_ack, read_data             one-cycle ack, zero-extended read data
//   ram_addr/ram_wdata/ram_we/ram_rd/ram_rdata/ram_ready  local RAM port
//   busy                            FSM not idle
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | waiting for a selected request
// RD_ISSUE    | ram_rd held until RAM accepts it
// RD_WAIT     | latency down-counter running, then capture ram_rdata
// WR_ISSUE    | ram_we held until RAM accepts it, one settle cycle after
// ACK         | data_ack high for this single cycle
// HOLD        | waiting for the streamer to drop its request
module save_state_chunk
  import save_state_pkg::*;
#(
  parameter int CHUNK_WORDS  = 1024,
  parameter int WIDTH_CODE   = 1,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1,
  localparam int DATA_W      = 8 << WIDTH_CODE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              chunk_sel,
  input  logic              query_req,
  input  logic              write_req,
  input  logic [63:0]       write_data,
  input  logic              read_req,
  input  logic [31:0]       chunk_address,
  output logic              data_ack,
  output logic [63:0]       read_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic              busy
);

  localparam int CNT_W = 3;
  localparam logic [63:0] DESCRIPTOR = make_descriptor(2'(WIDTH_CODE), 32'(CHUNK_WORDS));

  chunk_state_t      r_state, w_state_n;
  logic              r_data_ack, w_data_ack_n;
  logic [63:0]       r_read_data, w_read_data_n;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_n;
  logic [DATA_W-1:0] r_ram_wdata, w_ram_wdata_n;
  logic              r_ram_we, w_ram_we_n;
  logic              r_ram_rd, w_ram_rd_n;
  logic              r_busy, w_busy_n;
  logic [CNT_W-1:0]  r_lat_cnt, w_lat_cnt_n;

  logic w_req_v;
  logic w_in_range;
  logic w_hdr_ok;
  logic w_unused_wdata;

  assign w_req_v    = enable & chunk_sel & (read_req | write_req);
  assign w_in_range = chunk_address < 32'(CHUNK_WORDS);
  assign w_hdr_ok   = (write_data[HDR_LEN_MSB:HDR_LEN_LSB] == 32'(CHUNK_WORDS)) &&
                      (write_data[HDR_WIDTH_MSB:HDR_WIDTH_LSB] == 2'(WIDTH_CODE));
  // Header bits above WIDTH (incl. INDEX) do not matter to this endpoint.
  assign w_unused_wdata = ^write_data[63:HDR_WIDTH_MSB+1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_data_ack  <= 1'b0;
      r_read_data <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
      r_ram_rd    <= 1'b0;
      r_busy      <= 1'b0;
      r_lat_cnt   <= '0;
    end else begin
      r_state     <= w_state_n;
      r_data_ack  <= w_data_ack_n;
      r_read_data <= w_read_data_n;
      r_ram_addr  <= w_ram_addr_n;
      r_ram_wdata <= w_ram_wdata_n;
      r_ram_we    <= w_ram_we_n;
      r_ram_rd    <= w_ram_rd_n;
      r_busy      <= w_busy_n;
      r_lat_cnt   <= w_lat_cnt_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_read_data_n = r_read_data;
    w_ram_addr_n  = r_ram_addr;
    w_ram_wdata_n = r_ram_wdata;
    w_ram_we_n    = r_ram_we;
    w_ram_rd_n    = r_ram_rd;
    w_lat_cnt_n   = r_lat_cnt;

    case (r_state)
      ST_IDLE: begin
        if (w_req_v) begin
          if (query_req) begin
            if (read_req) begin
              w_read_data_n = DESCRIPTOR;
              w_state_n     = ST_ACK;
            end else if (w_hdr_ok) begin
              w_state_n = ST_ACK;
            end
            // Bad header: stay silent so the streamer times out and skips us.
          end else if (read_req) begin
            if (w_in_range) begin
              w_ram_addr_n = chunk_address[ADDR_W-1:0];
              w_ram_rd_n   = 1'b1;
              w_state_n    = ST_RD_ISSUE;
            end else begin
              w_read_data_n = '0;
              w_state_n     = ST_ACK;
            end
          end else begin
            if (w_in_range) begin
              w_ram_addr_n  = chunk_address[ADDR_W-1:0];
              w_ram_wdata_n = write_data[DATA_W-1:0];
              w_ram_we_n    = 1'b1;
              w_state_n     = ST_WR_ISSUE;
            end else begin
              w_state_n = ST_ACK;
            end
          end
        end
      end
      ST_RD_ISSUE: begin
        if (ram_ready) begin
          w_ram_rd_n  = 1'b0;
          w_lat_cnt_n = CNT_W'(READ_LATENCY);
          w_state_n   = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (r_lat_cnt == '0) begin
          w_read_data_n = 64'(ram_rdata);
          w_state_n     = ST_ACK;
        end else begin
          w_lat_cnt_n = r_lat_cnt - 1'b1;
        end
      end
      ST_WR_ISSUE: begin
        // First drop the strobe once accepted, ack on the following cycle.
        if (r_ram_we) begin
          if (ram_ready) w_ram_we_n = 1'b0;
        end else begin
          w_state_n = ST_ACK;
        end
      end
      ST_ACK: w_state_n = ST_HOLD;
      ST_HOLD: begin
        if (!read_req && !write_req) w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase

    if ((r_state != ST_IDLE) && !(enable && chunk_sel)) begin
      w_state_n     = ST_IDLE;
      w_read_data_n = '0;
      w_ram_addr_n  = '0;
      w_ram_wdata_n = '0;
      w_ram_we_n    = 1'b0;
      w_ram_rd_n    = 1'b0;
      w_lat_cnt_n   = '0;
    end
  end

  assign w_data_ack_n = (w_state_n == ST_ACK);
  assign w_busy_n     = (w_state_n != ST_IDLE);

  assign data_ack  = r_data_ack;
  assign read_data = r_read_data;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_we    = r_ram_we;
  assign ram_rd    = r_ram_rd;
  assign busy      = r_busy;

endmodule

// File: tb/tb_save_state_chunk.sv
module tb_save_state_chunk;

  localparam int CW = 1024;
  localparam int WC = 1;
  localparam int AW = 10;
  localparam int RL = 2;
  localparam int DW = 16;

  localparam int K_QRD = 0;
  localparam int K_QWR = 1;
  localparam int K_RD  = 2;
  localparam int K_WR  = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          chunk_sel = 1'b0;
  logic          query_req = 1'b0;
  logic          write_req = 1'b0;
  logic [63:0]   write_data = '0;
  logic          read_req = 1'b0;
  logic [31:0]   chunk_address = '0;
  logic          data_ack;
  logic [63:0]   read_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic          ram_rd;
  logic [DW-1:0] ram_rdata;
  logic          ram_ready = 1'b1;
  logic          busy;

  save_state_chunk #(
    .CHUNK_WORDS(CW), .WIDTH_CODE(WC), .ADDR_W(AW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .chunk_sel(chunk_sel),
    .query_req(query_req), .write_req(write_req), .write_data(write_data),
    .read_req(read_req), .chunk_address(chunk_address), .data_ack(data_ack),
    .read_data(read_data), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rd(ram_rd), .ram_rdata(ram_rdata),
    .ram_ready(ram_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Local RAM: read data appears RL cycles after an accepted ram_rd,
  // with garbage on the bus until then.
  logic [DW-1:0] ram_mem [0:CW-1];
  logic [AW-1:0] rd_addr;
  logic          rd_pend;
  int            rd_wait;
  logic          mem_clr = 1'b1;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < CW; i++) ram_mem[i] <= '0;
      rd_pend   <= 1'b0;
      rd_wait   <= 0;
      rd_addr   <= '0;
      ram_rdata <= '0;
    end else begin
      if (ram_we && ram_ready) ram_mem[ram_addr] <= ram_wdata;
      if (ram_rd && ram_ready) begin
        rd_addr   <= ram_addr;
        rd_pend   <= 1'b1;
        rd_wait   <= RL - 1;
        ram_rdata <= DW'($urandom);
      end else if (rd_pend) begin
        if (rd_wait == 0) begin
          ram_rdata <= ram_mem[rd_addr];
          rd_pend   <= 1'b0;
        end else begin
          rd_wait <= rd_wait - 1;
        end
      end
    end
  end

  // Reference model state
  typedef struct {
    int          cyc;
    logic [63:0] data;
    bit          chk;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] exp_mem [0:CW-1];
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_acks = 0;
  int          rd_cycles = 0;
  int          we_cycles = 0;
  logic [63:0] last_ack_data = '0;

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && !mem_clr) begin
      if (data_ack) begin
        n_acks++;
        last_ack_data = read_data;
        if (exp_q.size() == 0) begin
          check64("unexpected_ack", 64'(data_ack), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check64("ack_cycle", 64'(cyc), 64'(e.cyc));
          if (e.chk) check64("ack_data", read_data, e.data);
        end
      end else if (exp_q.size() > 0 && cyc >= exp_q[0].cyc) begin
        void'(exp_q.pop_front());
        check64("missing_ack", 64'(data_ack), 64'd1);
      end
      if (ram_rd) begin
        rd_cycles++;
        check64("rd_addr", 64'(ram_addr), 64'(exp_addr));
      end
      if (ram_we) begin
        we_cycles++;
        check64("we_addr", 64'(ram_addr), 64'(exp_addr));
        check64("we_data", 64'(ram_wdata), 64'(exp_wdata));
      end
    end
  end

  // One streamer transaction; the expected ack cycle, data and RAM traffic
  // come from the element-level rules, not from the DUT.
  task automatic do_txn(input int kind, input logic [31:0] addr,
                        input logic [63:0] data, input int stall);
    int   lat;
    int   left;
    int   exp_rd;
    int   exp_we;
    bit   want_ack;
    exp_t e;
    @(negedge clk);
    rd_cycles     = 0;
    we_cycles     = 0;
    query_req     = (kind == K_QRD) || (kind == K_QWR);
    read_req      = (kind == K_QRD) || (kind == K_RD);
    write_req     = (kind == K_QWR) || (kind == K_WR);
    chunk_address = addr;
    write_data    = data;
    lat = 1; exp_rd = 0; exp_we = 0; want_ack = 1'b1;
    e.data = '0; e.chk = 1'b0;
    case (kind)
      K_QRD: begin
        e.data = {30'b0, 2'(WC), 32'(CW)};
        e.chk  = 1'b1;
      end
      K_QWR: want_ack = (data[31:0] == 32'(CW)) && (data[33:32] == 2'(WC));
      K_RD: begin
        e.chk = 1'b1;
        if (addr < 32'(CW)) begin
          lat      = 3 + RL + stall;
          e.data   = 64'(exp_mem[addr[AW-1:0]]);
          exp_addr = addr[AW-1:0];
          exp_rd   = stall + 1;
        end
      end
      default: begin
        if (addr < 32'(CW)) begin
          lat       = 3 + stall;
          exp_addr  = addr[AW-1:0];
          exp_wdata = data[DW-1:0];
          exp_mem[addr[AW-1:0]] = data[DW-1:0];
          exp_we    = stall + 1;
        end
      end
    endcase
    if (want_ack) begin
      e.cyc = cyc + lat;
      exp_q.push_back(e);
    end else begin
      lat = 20;
    end
    left = stall;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (ram_rd || ram_we) begin
        if (left > 0) begin
          ram_ready = 1'b0;
          left--;
        end else begin
          ram_ready = 1'b1;
        end
      end else begin
        ram_ready = 1'b1;
      end
    end
    query_req = 1'b0;
    read_req  = 1'b0;
    write_req = 1'b0;
    ram_ready = 1'b1;
    @(negedge clk);
    check64("busy_after_txn", 64'(busy), 64'd0);
    check64("rd_strobe_cycles", 64'(rd_cycles), 64'(exp_rd));
    check64("we_strobe_cycles", 64'(we_cycles), 64'(exp_we));
  endtask

  initial begin
    int          acks0;
    int          n;
    logic [63:0] good_hdr;
    logic [63:0] d;
    for (int i = 0; i < CW; i++) exp_mem[i] = '0;

    repeat (3) @(negedge clk);
    #1;
    check64("rst_data_ack", 64'(data_ack), 64'd0);
    check64("rst_read_data", read_data, 64'd0);
    check64("rst_ram_addr", 64'(ram_addr), 64'd0);
    check64("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    check64("rst_ram_we", 64'(ram_we), 64'd0);
    check64("rst_ram_rd", 64'(ram_rd), 64'd0);
    check64("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    mem_clr   = 1'b0;
    reset_n   = 1'b1;
    enable    = 1'b1;
    chunk_sel = 1'b1;
    @(negedge clk);

    // 1: gather query
    do_txn(K_QRD, 32'd0, 64'd0, 0);
    check64("t1_descriptor", last_ack_data, 64'h0000_0001_0000_0400);

    // 2: scatter header good / bad
    acks0 = n_acks;
    do_txn(K_QWR, 32'd0, 64'h0000_0001_0000_0400, 0);
    check64("t2_good_hdr_acks", 64'(n_acks - acks0), 64'd1);
    acks0 = n_acks;
    do_txn(K_QWR, 32'd0, 64'h0000_0001_0000_0200, 0);
    check64("t2_bad_hdr_acks", 64'(n_acks - acks0), 64'd0);

    // 3: element write
    acks0 = n_acks;
    do_txn(K_WR, 32'd5, 64'hDEAD_BEEF_CAFE_1234, 0);
    check64("t3_ram_word", 64'(ram_mem[5]), 64'h1234);
    check64("t3_acks", 64'(n_acks - acks0), 64'd1);

    // 4: element read with ram_ready low for 3 cycles
    acks0 = n_acks;
    do_txn(K_RD, 32'd5, 64'd0, 3);
    check64("t4_read_data", last_ack_data, 64'h1234);
    check64("t4_rd_held", 64'(rd_cycles), 64'd4);
    check64("t4_acks", 64'(n_acks - acks0), 64'd1);

    // 5: out-of-range element
    do_txn(K_RD, 32'd1024, 64'd0, 0);
    check64("t5_oor_read_data", last_ack_data, 64'd0);
    do_txn(K_WR, 32'd1024, 64'h0123_4567_89AB_CDEF, 0);
    check64("t5_oor_no_write", 64'(ram_mem[0]), 64'(exp_mem[0]));

    // 6a: reset while waiting on RAM read latency
    acks0 = n_acks;
    @(negedge clk);
    exp_addr      = 10'd5;
    chunk_address = 32'd5;
    read_req      = 1'b1;
    repeat (3) @(negedge clk);
    check64("t6a_busy_before", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check64("t6a_ack", 64'(data_ack), 64'd0);
    check64("t6a_rd", 64'(ram_rd), 64'd0);
    check64("t6a_busy", 64'(busy), 64'd0);
    check64("t6a_read_data", read_data, 64'd0);
    read_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check64("t6a_no_ack", 64'(n_acks - acks0), 64'd0);

    // 6b: chunk_sel dropped while the write strobe is stalled
    @(negedge clk);
    exp_addr      = 10'd9;
    exp_wdata     = 16'h5555;
    chunk_address = 32'd9;
    write_data    = 64'hAAAA_5555;
    write_req     = 1'b1;
    ram_ready     = 1'b0;
    repeat (2) @(negedge clk);
    check64("t6b_we_before", 64'(ram_we), 64'd1);
    chunk_sel = 1'b0;
    @(negedge clk);
    check64("t6b_busy", 64'(busy), 64'd0);
    check64("t6b_we", 64'(ram_we), 64'd0);
    check64("t6b_ack", 64'(data_ack), 64'd0);
    write_req = 1'b0;
    chunk_sel = 1'b1;
    ram_ready = 1'b1;
    repeat (4) @(negedge clk);
    check64("t6b_no_ack", 64'(n_acks - acks0), 64'd0);
    check64("t6b_mem_untouched", 64'(ram_mem[9]), 64'(exp_mem[9]));
    do_txn(K_RD, 32'd5, 64'd0, 0);
    check64("t6_next_read", last_ack_data, 64'h1234);

    // Randomized traffic
    good_hdr = {30'b0, 2'(WC), 32'(CW)};
    for (int t = 0; t < 200; t++) begin
      n = int'($urandom_range(0, 9));
      d = {$urandom, $urandom};
      case (n)
        0: do_txn(K_QRD, $urandom, d, 0);
        1: do_txn(K_QWR, 32'd0, {d[63:34], good_hdr[33:0]}, 0);
        2: do_txn(K_QWR, 32'd0,
                  {d[63:34], good_hdr[33:0] ^ 34'(64'd1 << $urandom_range(0, 33))}, 0);
        3, 4, 5: do_txn(K_WR, ($urandom_range(0, 7) == 0) ? 32'd1023 : 32'($urandom_range(0, 15)),
                        d, int'($urandom_range(0, 3)));
        6, 7, 8: do_txn(K_RD, ($urandom_range(0, 7) == 0) ? 32'd1023 : 32'($urandom_range(0, 15)),
                        d, int'($urandom_range(0, 3)));
        default: begin
          if ($urandom_range(0, 1) == 0)
            do_txn(K_RD, 32'd1024 + $urandom_range(0, 1000), d, 0);
          else
            do_txn(K_WR, 32'h8000_0000 | $urandom, d, 0);
        end
      endcase
    end
    repeat (4) @(negedge clk);
    check64("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
